vga_fb_addr_gen: RTL and testbench

Parametrised frame-buffer read-address generator for the VGA output path of the OV7670 capture design, clocked by CLK25. It converts a per-pixel enable and the frame vsync into a linear read address, with pixel counters aligned to each frame. It supports 1x/2x/4x pixel replication so 640x480, 320x240 and 160x120 stored frames all fill the display. Its registered address/valid pair feeds the frame-buffer RAM read port; it replaces the fixed-resolution generator, and the first active pixel of every frame maps exactly to address 0.

---
 rtl/vga_fb_addr_gen.sv | 139 +++++++++++++
 tb/tb_vga_fb_addr_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_addr_gen.sv
// Frame-buffer read-address generator for the VGA path: converts per-pixel enables
// into linear addresses with 1x/2x/4x pixel replication, realigned on every vsync low.
module vga_fb_addr_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              CLK25,
  input  logic              reset,
  input  logic              vsync,
  input  logic              enable,
  input  logic [1:0]        scale,
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACTIVE    = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XW-1:0]     r_x, w_x_nxt;
  logic [YW-1:0]     r_y, w_y_nxt;
  logic [ADDR_W-1:0] r_line_base, w_line_base_nxt;
  logic [1:0]        r_scale_q, w_scale_q_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic              r_addr_valid, w_addr_valid_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_overrun, w_overrun_nxt;

  logic [1:0]        w_shift;
  logic [1:0]        w_mask;
  logic [ADDR_W-1:0] w_sw;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [YW-1:0]     w_y_inc;
  logic              w_x_last;
  logic              w_y_last;

  // Scale 3 is treated as 1x; mask selects how many lines share one source line.
  assign w_shift    = (r_scale_q == 2'd3) ? 2'd0 : r_scale_q;
  assign w_mask     = (w_shift == 2'd0) ? 2'b00 : ((w_shift == 2'd1) ? 2'b01 : 2'b11);
  assign w_sw       = ADDR_W'(H_ACTIVE) >> w_shift;
  assign w_pix_addr = r_line_base + (ADDR_W'(r_x) >> w_shift);
  assign w_y_inc    = r_y + YW'(1);
  assign w_x_last   = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_last   = (r_y == YW'(V_ACTIVE - 1));

  always_ff @(posedge CLK25) begin
    if (reset) r_state <= WAIT_SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_line_base_nxt  = r_line_base;
    w_scale_q_nxt    = r_scale_q;
    w_address_nxt    = r_address;
    w_addr_valid_nxt = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_overrun_nxt    = r_overrun;

    if (!vsync) begin
      // Frame restart takes priority over any enable in the same cycle.
      w_state_nxt     = ACTIVE;
      w_x_nxt         = '0;
      w_y_nxt         = '0;
      w_line_base_nxt = '0;
      w_address_nxt   = '0;
      w_scale_q_nxt   = scale;
      w_overrun_nxt   = 1'b0;
    end else begin
      case (r_state)
        ACTIVE: begin
          if (enable) begin
            w_address_nxt    = w_pix_addr;
            w_addr_valid_nxt = 1'b1;
            if (w_x_last) begin
              w_x_nxt = '0;
              if (w_y_last) begin
                w_y_nxt          = '0;
                w_line_base_nxt  = '0;
                w_state_nxt      = DONE;
                w_frame_done_nxt = 1'b1;
              end else begin
                w_y_nxt = w_y_inc;
                // Advance to the next source line only after its replication count.
                if ((w_y_inc[1:0] & w_mask) == 2'b00)
                  w_line_base_nxt = r_line_base + w_sw;
              end
            end else begin
              w_x_nxt = r_x + XW'(1);
            end
          end
        end
        DONE: begin
          if (enable) w_overrun_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK25) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_line_base  <= '0;
      r_scale_q    <= '0;
      r_address    <= '0;
      r_addr_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_line_base  <= w_line_base_nxt;
      r_scale_q    <= w_scale_q_nxt;
      r_address    <= w_address_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign address    = r_address;
  assign addr_valid = r_addr_valid;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_vga_fb_addr_gen.sv
// Scoreboard bench for vga_fb_addr_gen on a reduced 64x32 frame so full frames stay short.
module tb_vga_fb_addr_gen;

  localparam int unsigned H  = 64;
  localparam int unsigned V  = 32;
  localparam int unsigned AW = 11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          done;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          vsync;
  logic          enable;
  logic [1:0]    scale;
  logic [AW-1:0] address;
  logic          addr_valid;
  logic          frame_done;
  logic          overrun;

  exp_t exp_q[$];
  int   obs[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   last_done_addr = -1;
  int   m_state, mx, my, ms;
  int   d0;

  vga_fb_addr_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .CLK25     (clk),
    .reset     (reset),
    .vsync     (vsync),
    .enable    (enable),
    .scale     (scale),
    .address   (address),
    .addr_valid(addr_valid),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference model pushes the expected output of accepted pixels.
  task automatic drive(input logic en, input logic vs, input logic [1:0] sc);
    exp_t e;
    @(negedge clk);
    reset  = 1'b0;
    enable = en;
    vsync  = vs;
    scale  = sc;
    if (!vs) begin
      m_state = 1; mx = 0; my = 0;
      ms = (sc == 2'd3) ? 0 : int'(sc);
    end else if (en && m_state == 1) begin
      e.addr = AW'(((my >> ms) * (H >> ms)) + (mx >> ms));
      e.done = (mx == H - 1) && (my == V - 1);
      exp_q.push_back(e);
      if (mx == H - 1) begin
        mx = 0;
        if (my == V - 1) begin my = 0; m_state = 2; end
        else my++;
      end else mx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_px(input int n, input logic [1:0] sc);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, sc);
  endtask

  task automatic sync(input int n, input logic [1:0] sc);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, sc);
    obs.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 2'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_address"}, int'(address), 0);
    chk({tag, "_addr_valid"}, int'(addr_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; vsync = 1'b1;
    m_state = 0; ms = 0; mx = 0; my = 0;
    @(posedge clk); #1;
  endtask

  // Monitor: every valid output is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (addr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got address %0d expected no output", address);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", int'(address), int'(e.addr));
        chk("sb_done", int'(frame_done), int'(e.done));
      end
      obs.push_back(int'(address));
      if (frame_done) begin
        done_cnt++;
        last_done_addr = int'(address);
      end
    end else if (frame_done === 1'b1) begin
      checks++; errors++;
      $display("FAIL done_without_valid: got frame_done 1 expected 0");
    end
  end

  initial begin
    reset = 1'b1; vsync = 1'b1; enable = 1'b0; scale = 2'd0;
    m_state = 0; mx = 0; my = 0; ms = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");

    // Enables before the first vsync low are ignored.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'd0);
    chk("presync_valid", int'(addr_valid), 0);
    chk("presync_overrun", int'(overrun), 0);

    // 1x full frame.
    sync(10, 2'd0);
    d0 = done_cnt;
    run_px(H * V, 2'd0);
    idle(2);
    chk("1x_first", obs[0], 0);
    chk("1x_count", obs.size(), 2048);
    chk("1x_last", last_done_addr, 2047);
    chk("1x_done_pulses", done_cnt - d0, 1);

    // Overrun after a complete frame.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd0);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_addr_hold", int'(address), 2047);
      chk("ovr_valid", int'(addr_valid), 0);
    end
    drive(1'b0, 1'b0, 2'd0);
    chk("ovr_clear", int'(overrun), 0);
    chk("ovr_addr_zero", int'(address), 0);

    // 2x replication.
    sync(1, 2'd1);
    run_px(H * V, 2'd1);
    idle(2);
    chk("2x_l0_x0", obs[0], 0);
    chk("2x_l0_x1", obs[1], 0);
    chk("2x_l0_x2", obs[2], 1);
    chk("2x_l0_x63", obs[63], 31);
    chk("2x_l1_x0", obs[64], 0);
    chk("2x_l1_x63", obs[127], 31);
    chk("2x_l2_x0", obs[128], 32);
    chk("2x_last", last_done_addr, 511);

    // 4x replication.
    sync(1, 2'd2);
    run_px(H * V, 2'd2);
    idle(2);
    chk("4x_l0_x4", obs[4], 1);
    chk("4x_l4_x0", obs[256], 16);
    chk("4x_l4_x4", obs[260], 17);
    chk("4x_last", last_done_addr, 127);

    // Scale 3 behaves as 1x.
    sync(1, 2'd3);
    run_px(H * V, 2'd3);
    idle(2);
    chk("s3_x5", obs[5], 5);
    chk("s3_last", last_done_addr, 2047);

    // Mid-frame restart with enable high during the vsync-low cycle.
    sync(1, 2'd0);
    run_px(1000, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    chk("restart_addr", int'(address), 0);
    chk("restart_valid", int'(addr_valid), 0);
    obs.delete();
    drive(1'b1, 1'b1, 2'd0);
    idle(1);
    chk("restart_count", obs.size(), 1);
    chk("restart_first", obs[0], 0);

    // Reset mid-frame, then enables ignored until vsync low.
    sync(1, 2'd0);
    run_px(500, 2'd0);
    do_reset();
    chk_zero("midreset");
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 2'd0);
    chk("midreset_ignore", int'(addr_valid), 0);

    // Scale change mid-frame takes effect only at the next vsync low.
    sync(1, 2'd0);
    run_px(100, 2'd0);
    run_px(H * V - 100, 2'd2);
    idle(2);
    chk("sc_px100", obs[100], 100);
    chk("sc_px101", obs[101], 101);
    chk("sc_last_1x", last_done_addr, 2047);
    sync(1, 2'd2);
    run_px(H * V, 2'd2);
    idle(2);
    chk("sc_last_4x", last_done_addr, 127);

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
